decode_dispatch: RTL and testbench
==================================

Name: decode_dispatch

Overview:
Parametrised RV32I decode/dispatch stage between instruction fetch and the ROB, RS and LSB. It buffers fetched instructions in an IQ_DEPTH-entry queue. It decodes the queue head, reads and bypasses operand tags, predicts branches statically and redirects fetch. It issues one instruction per cycle through registered outputs, and supports flush and a JALR wait state.

Parameters:
ROB_W, 4, ROB index width; ROB holds 2^ROB_W entries
IQ_DEPTH, 4, instruction queue entries; power of 2, at least 2
PRED_BWD, 1, 1 = backward branches predicted taken; 0 = all branches predicted not-taken

Ports:
clk  in  1  clock
rst  in  1  reset
rdy  in  1  global enable; 0 freezes all state
flush  in  1  ROB mispredict/JALR resolve flush
flush_tail  in  ROB_W  ROB tail to resume ROB-id allocation from after a flush
if_valid  in  1  fetch offers an instruction
if_pc  in  32  fetched PC
if_inst  in  32  fetched instruction
if_ready  out  1  queue can accept an instruction (not full)
redir_valid  out  1  one-cycle pulse: refetch from redir_pc
redir_pc  out  32  predicted target
rs1_id, rs2_id  out  5 each  register-file read addresses (head instruction, combinational)
rs1_val, rs2_val  in  32 each  register values
rs1_busy, rs2_busy  in  1 each  register renamed
rs1_tag, rs2_tag  in  ROB_W each  producing ROB entry
rob_full, rs_full, lsb_full  in  1 each  almost-full: asserted while at most one free slot remains
out_rob_valid, out_rs_valid, out_lsb_valid  out  1 each  dispatch strobes, registered
out_rob_id  out  ROB_W  allocated ROB entry
out_rd  out  5  destination register
out_opcode  out  7  opcode
out_funct3  out  3  funct3
out_f7b5  out  1  inst[30]
out_v1, out_v2  out  32 each  operand values
out_q1, out_q2  out  ROB_W each  operand tags
out_has_q1, out_has_q2  out  1 each  operand waiting on a tag
out_imm  out  32  sign-extended immediate, or computed result for LUI/AUIPC/JAL/JALR
out_pc  out  32  instruction PC
out_pred_taken  out  1  branch predicted taken
out_exit  out  1  instruction is 32'hff9ff06f
rename_valid  out  1  register file must set rd's tag to out_rob_id; 0 when rd == x0

Behaviour:
- Reset: rst is asynchronous and active-high; clock is clk. On reset: queue empty, state RUN, alloc counter 0, every out_* and rename_valid, redir_valid = 0, redir_pc = 0.
- Freeze: rdy = 0 holds all state; strobes keep their values.
- Queue: circular buffer with ptr width log2(IQ_DEPTH)+1; wrap-around by pointer MSB.
  - if_ready = !full.
  - Enqueue on if_valid && if_ready, unless a flush or redirect occurs that cycle.
  - Simultaneous enqueue and dequeue when full is not allowed, because if_ready is low.
- Dispatch condition (fire): state RUN && !flush && queue non-empty && !rob_full && (!rs_full || the op is not B/R/I) && (!lsb_full || the op is not load/store).
- On fire, the head is dequeued and outputs register at the next edge, giving 1-cycle latency. Without fire, all strobes drop to 0.
- Routing:
  - Every dispatched op sets out_rob_valid.
  - R, I and B ops also set out_rs_valid.
  - Load and store ops also set out_lsb_valid.
  - Unknown opcode: ROB only, with out_opcode passed through.
- Operands:
  - v1/q1 come from rs1.
  - v2 = rs2_val for R, B and S.
  - For I-type, v2 = shamt (funct3 001 or 101) or sign-extended immI, with has_q2 = 0.
  - has_q is forced to 0 when the format does not use that source, or when the source is x0.
- Immediates:
  - immI for load/ALU-I; immS for store; immB for branch.
  - LUI: imm = {immU, 12'b0}.
  - AUIPC: imm = pc + {immU, 12'b0}.
  - JAL/JALR: imm = pc + 4. JALR carries immI in v2.
- Bypass: if the previous cycle fired with rename_valid and out_rd equals a used source register, that source gets has_q = 1 and q = the previous out_rob_id. This overrides the register-file values.
- Allocation: out_rob_id = alloc counter; the counter increments mod 2^ROB_W on fire. On flush the counter loads flush_tail.
- Prediction:
  - B: taken iff PRED_BWD && immB[12]. If taken, redir_valid = 1 and redir_pc = pc + immB.
  - JAL: always redirect to pc + immJ.
  - A redirect clears the queue in the same edge, excluding the head being dispatched, and suppresses that cycle's enqueue.
  - out_pred_taken records the prediction.
- States:
  - RUN → WAIT_JALR on JALR fire.
  - In WAIT_JALR: no dispatch; the queue still fills; the state clears only on flush.
- Flush: takes priority over everything. Queue is emptied, state goes to RUN, strobes and redir_valid are 0 next cycle, and the counter loads flush_tail.
- rst mid-operation discards all queued and in-flight outputs.

Test Plan:
- Enqueue ADDI x1,x0,5 at pc 0x0, then ADD x2,x1,x1 → cycle 1: rs_valid, rob_id 0, v2 = 5, rename. Next: has_q1 = has_q2 = 1, q = 0 (bypass), rob_id 1.
- BEQ at 0x100 with imm -8 and PRED_BWD = 1 → redir_valid, redir_pc 0xF8, pred_taken 1, younger queue entries dropped. Repeat with PRED_BWD = 0 → no redirect.
- JALR x1,0(x5) at 0x40 → imm 0x44, state WAIT_JALR, no further dispatch. flush with flush_tail = 3 → next dispatch rob_id 3.
- Fill the queue to IQ_DEPTH with lsb_full held at 1 and loads at the head → if_ready 0, no strobes. Release lsb_full → lsb_valid, in order.
- LUI x3,0x12345 → imm 0x12345000, ROB only, rename. Instruction 0xff9ff06f → out_exit 1.
- Assert rst mid-dispatch with rdy toggling → all outputs 0 immediately, queue empty after release.

Source files
------------

// File: rtl/decode_dispatch.sv
// decode_dispatch: RV32I fetch queue + decode/dispatch to ROB/RS/LSB; in: fetch, regfile read data, full flags, flush; out: if_ready, redirect, regfile read ids, registered dispatch bundle, rename
module decode_dispatch #(
  parameter int ROB_W = 4,
  parameter int IQ_DEPTH = 4,
  parameter bit PRED_BWD = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic [ROB_W-1:0] flush_tail,
  input  logic             if_valid,
  input  logic [31:0]      if_pc,
  input  logic [31:0]      if_inst,
  output logic             if_ready,
  output logic             redir_valid,
  output logic [31:0]      redir_pc,
  output logic [4:0]       rs1_id,
  output logic [4:0]       rs2_id,
  input  logic [31:0]      rs1_val,
  input  logic [31:0]      rs2_val,
  input  logic             rs1_busy,
  input  logic             rs2_busy,
  input  logic [ROB_W-1:0] rs1_tag,
  input  logic [ROB_W-1:0] rs2_tag,
  input  logic             rob_full,
  input  logic             rs_full,
  input  logic             lsb_full,
  output logic             out_rob_valid,
  output logic             out_rs_valid,
  output logic             out_lsb_valid,
  output logic [ROB_W-1:0] out_rob_id,
  output logic [4:0]       out_rd,
  output logic [6:0]       out_opcode,
  output logic [2:0]       out_funct3,
  output logic             out_f7b5,
  output logic [31:0]      out_v1,
  output logic [31:0]      out_v2,
  output logic [ROB_W-1:0] out_q1,
  output logic [ROB_W-1:0] out_q2,
  output logic             out_has_q1,
  output logic             out_has_q2,
  output logic [31:0]      out_imm,
  output logic [31:0]      out_pc,
  output logic             out_pred_taken,
  output logic             out_exit,
  output logic             rename_valid
);
  localparam int AW = $clog2(IQ_DEPTH);
  localparam int PW = AW + 1;
  typedef enum logic {RUN, WAIT_JALR} state_t;
  typedef struct packed {
    logic             rob_v;
    logic             rs_v;
    logic             lsb_v;
    logic [ROB_W-1:0] rob_id;
    logic [4:0]       rd;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             f7b5;
    logic [31:0]      v1;
    logic [31:0]      v2;
    logic [ROB_W-1:0] q1;
    logic [ROB_W-1:0] q2;
    logic             has_q1;
    logic             has_q2;
    logic [31:0]      imm;
    logic [31:0]      pc;
    logic             pred_taken;
    logic             ex;
    logic             rename;
  } pl_t;
  state_t state_q, state_d;
  pl_t pl_q, pl_d, nw;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [ROB_W-1:0] alloc_q, alloc_d;
  logic redir_valid_q, redir_valid_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic [31:0] iq_pc_q [IQ_DEPTH];
  logic [31:0] iq_inst_q [IQ_DEPTH];
  logic [31:0] inst, pc, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [6:0] op;
  logic [2:0] f3;
  logic is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_opi, is_op;
  logic is_rs, is_lsb, use1, use2, wr, empty, full, fire, taken, redirect, enq, byp1, byp2;
  assign inst = iq_inst_q[head_q[AW-1:0]];
  assign pc = iq_pc_q[head_q[AW-1:0]];
  assign op = inst[6:0];
  assign f3 = inst[14:12];
  assign is_lui = op == 7'b0110111;
  assign is_auipc = op == 7'b0010111;
  assign is_jal = op == 7'b1101111;
  assign is_jalr = op == 7'b1100111;
  assign is_br = op == 7'b1100011;
  assign is_ld = op == 7'b0000011;
  assign is_st = op == 7'b0100011;
  assign is_opi = op == 7'b0010011;
  assign is_op = op == 7'b0110011;
  assign is_rs = is_br | is_op | is_opi;
  assign is_lsb = is_ld | is_st;
  assign use1 = is_jalr | is_rs | is_lsb;
  assign use2 = is_br | is_st | is_op;
  assign wr = is_lui | is_auipc | is_jal | is_jalr | is_ld | is_opi | is_op;
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  assign rs1_id = inst[19:15];
  assign rs2_id = inst[24:20];
  assign empty = head_q == tail_q;
  assign full = tail_q == {~head_q[AW], head_q[AW-1:0]};
  assign if_ready = !full;
  assign fire = state_q == RUN && !flush && !empty && !rob_full && !(rs_full && is_rs) && !(lsb_full && is_lsb);
  assign taken = is_jal || (is_br && PRED_BWD && inst[31]);
  assign redirect = fire && taken;
  assign enq = if_valid && !full && !flush && !redirect;
  assign byp1 = pl_q.rename && pl_q.rd == rs1_id;
  assign byp2 = pl_q.rename && pl_q.rd == rs2_id;
  always_comb begin
    nw = '0;
    nw.rob_v = 1'b1;
    nw.rs_v = is_rs;
    nw.lsb_v = is_lsb;
    nw.rob_id = alloc_q;
    nw.rd = inst[11:7];
    nw.opcode = op;
    nw.funct3 = f3;
    nw.f7b5 = inst[30];
    nw.v1 = use1 ? rs1_val : '0;
    nw.v2 = use2 ? rs2_val : (is_opi && f3[1:0] == 2'b01) ? {27'b0, inst[24:20]} : (is_opi | is_jalr) ? imm_i : '0;
    nw.has_q1 = use1 && rs1_id != 5'd0 && (byp1 || rs1_busy);
    nw.has_q2 = use2 && rs2_id != 5'd0 && (byp2 || rs2_busy);
    nw.q1 = byp1 ? pl_q.rob_id : rs1_tag;
    nw.q2 = byp2 ? pl_q.rob_id : rs2_tag;
    nw.imm = is_lui ? imm_u : is_auipc ? pc + imm_u : (is_jal | is_jalr) ? pc + 32'd4 :
             is_br ? imm_b : is_st ? imm_s : (is_ld | is_opi) ? imm_i : '0;
    nw.pc = pc;
    nw.pred_taken = taken;
    nw.ex = inst == 32'hff9ff06f;
    nw.rename = wr && inst[11:7] != 5'd0;
    pl_d = pl_q;
    pl_d.rob_v = 1'b0;
    pl_d.rs_v = 1'b0;
    pl_d.lsb_v = 1'b0;
    pl_d.rename = 1'b0;
    if (fire) pl_d = nw;
    head_d = head_q + PW'(fire);
    tail_d = flush ? head_q : redirect ? head_d : enq ? tail_q + PW'(1) : tail_q;
    alloc_d = flush ? flush_tail : alloc_q + ROB_W'(fire);
    state_d = flush ? RUN : (fire && is_jalr) ? WAIT_JALR : state_q;
    redir_valid_d = redirect;
    redir_pc_d = redirect ? pc + (is_br ? imm_b : imm_j) : redir_pc_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= RUN;
      pl_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      alloc_q <= '0;
      redir_valid_q <= 1'b0;
      redir_pc_q <= '0;
    end else if (rdy) begin
      state_q <= state_d;
      pl_q <= pl_d;
      head_q <= head_d;
      tail_q <= tail_d;
      alloc_q <= alloc_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q <= redir_pc_d;
    end
  always_ff @(posedge clk)
    if (rdy && enq) begin
      iq_pc_q[tail_q[AW-1:0]] <= if_pc;
      iq_inst_q[tail_q[AW-1:0]] <= if_inst;
    end
  assign redir_valid = redir_valid_q;
  assign redir_pc = redir_pc_q;
  assign out_rob_valid = pl_q.rob_v;
  assign out_rs_valid = pl_q.rs_v;
  assign out_lsb_valid = pl_q.lsb_v;
  assign out_rob_id = pl_q.rob_id;
  assign out_rd = pl_q.rd;
  assign out_opcode = pl_q.opcode;
  assign out_funct3 = pl_q.funct3;
  assign out_f7b5 = pl_q.f7b5;
  assign out_v1 = pl_q.v1;
  assign out_v2 = pl_q.v2;
  assign out_q1 = pl_q.q1;
  assign out_q2 = pl_q.q2;
  assign out_has_q1 = pl_q.has_q1;
  assign out_has_q2 = pl_q.has_q2;
  assign out_imm = pl_q.imm;
  assign out_pc = pl_q.pc;
  assign out_pred_taken = pl_q.pred_taken;
  assign out_exit = pl_q.ex;
  assign rename_valid = pl_q.rename;
endmodule

// File: tb/tb_decode_dispatch.sv
// tb_decode_dispatch: directed and randomized checks of decode_dispatch against a field-level reference model
module tb_decode_dispatch;
  localparam int ROB_W = 4;
  localparam int NRND = 80;
  typedef struct {
    int kind;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic f7b5;
    logic [31:0] imm, pc;
  } rec_t;
  logic clk = 1'b0, rst = 1'b1, rdy = 1'b1, flush = 1'b0;
  logic [ROB_W-1:0] flush_tail = '0;
  logic if_valid = 1'b0;
  logic [31:0] if_pc = '0, if_inst = '0;
  logic rob_full = 1'b0, rs_full = 1'b0, lsb_full = 1'b0;
  logic if_ready, redir_valid;
  logic [31:0] redir_pc;
  logic [4:0] rs1_id, rs2_id;
  logic [31:0] rs1_val, rs2_val;
  logic rs1_busy, rs2_busy;
  logic [ROB_W-1:0] rs1_tag, rs2_tag;
  logic out_rob_valid, out_rs_valid, out_lsb_valid;
  logic [ROB_W-1:0] out_rob_id, out_q1, out_q2;
  logic [4:0] out_rd;
  logic [6:0] out_opcode;
  logic [2:0] out_funct3;
  logic out_f7b5, out_has_q1, out_has_q2, out_pred_taken, out_exit, rename_valid;
  logic [31:0] out_v1, out_v2, out_imm, out_pc;
  logic [31:0] rf_val [32];
  logic rf_busy [32];
  logic [ROB_W-1:0] rf_tag [32];
  int total = 0, passed = 0, failed = 0, cyc = 0;
  int sent, idle, prev_cyc, exp_id, simm, shamt;
  logic prev_ren;
  logic [4:0] prev_rd;
  logic [31:0] u, inst, pc_ctr;
  rec_t r, e;
  rec_t exp_q[$];

  assign rs1_val = rf_val[rs1_id];
  assign rs2_val = rf_val[rs2_id];
  assign rs1_busy = rf_busy[rs1_id];
  assign rs2_busy = rf_busy[rs2_id];
  assign rs1_tag = rf_tag[rs1_id];
  assign rs2_tag = rf_tag[rs2_id];

  decode_dispatch #(.ROB_W(ROB_W), .IQ_DEPTH(4), .PRED_BWD(1'b1)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .flush_tail(flush_tail),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_ready(if_ready),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rs1_tag(rs1_tag), .rs2_tag(rs2_tag), .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
    .out_rob_valid(out_rob_valid), .out_rs_valid(out_rs_valid), .out_lsb_valid(out_lsb_valid),
    .out_rob_id(out_rob_id), .out_rd(out_rd), .out_opcode(out_opcode), .out_funct3(out_funct3),
    .out_f7b5(out_f7b5), .out_v1(out_v1), .out_v2(out_v2), .out_q1(out_q1), .out_q2(out_q2),
    .out_has_q1(out_has_q1), .out_has_q2(out_has_q2), .out_imm(out_imm), .out_pc(out_pc),
    .out_pred_taken(out_pred_taken), .out_exit(out_exit), .rename_valid(rename_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] ins);
    if_valid = 1'b1;
    if_pc = pc;
    if_inst = ins;
    step();
    if_valid = 1'b0;
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [6:0] kind_op(input int k);
    case (k)
      0: return 7'h33;
      1, 2: return 7'h13;
      3: return 7'h03;
      4: return 7'h23;
      5: return 7'h37;
      default: return 7'h17;
    endcase
  endfunction

  task automatic check_rec(input rec_t x);
    logic use1, use2, wr, b1, b2, hq1, hq2;
    use1 = x.kind <= 4;
    use2 = x.kind == 0 || x.kind == 4;
    wr = x.kind != 4;
    b1 = prev_cyc == cyc - 1 && prev_ren && prev_rd == x.rs1;
    b2 = prev_cyc == cyc - 1 && prev_ren && prev_rd == x.rs2;
    hq1 = use1 && x.rs1 != 5'd0 && (b1 || rf_busy[x.rs1]);
    hq2 = use2 && x.rs2 != 5'd0 && (b2 || rf_busy[x.rs2]);
    chk("rnd_rob_id", out_rob_id, exp_id[ROB_W-1:0]);
    chk("rnd_rs_valid", out_rs_valid, x.kind <= 2);
    chk("rnd_lsb_valid", out_lsb_valid, x.kind == 3 || x.kind == 4);
    chk("rnd_opcode", out_opcode, kind_op(x.kind));
    chk("rnd_pc", out_pc, x.pc);
    chk("rnd_rename", rename_valid, wr && x.rd != 5'd0);
    chk("rnd_redir", redir_valid, 1'b0);
    chk("rnd_has_q1", out_has_q1, hq1);
    chk("rnd_has_q2", out_has_q2, hq2);
    if (wr) chk("rnd_rd", out_rd, x.rd);
    if (x.kind <= 4) chk("rnd_funct3", out_funct3, x.f3);
    if (use1) chk("rnd_v1", out_v1, rf_val[x.rs1]);
    if (hq1) chk("rnd_q1", out_q1, b1 ? 32'(prev_rd == x.rs1 ? exp_id - 1 : 0) & 32'hf : rf_tag[x.rs1]);
    if (hq2) chk("rnd_q2", out_q2, b2 ? 32'(exp_id - 1) & 32'hf : rf_tag[x.rs2]);
    if (use2) chk("rnd_v2", out_v2, rf_val[x.rs2]);
    if (x.kind == 1 || x.kind == 2) chk("rnd_v2_imm", out_v2, x.imm);
    if (x.kind == 0 || x.kind == 2) chk("rnd_f7b5", out_f7b5, x.f7b5);
    if (x.kind == 1 || x.kind >= 3) chk("rnd_imm", out_imm, x.kind == 6 ? x.pc + x.imm : x.imm);
    prev_cyc = cyc;
    prev_ren = wr && x.rd != 5'd0;
    prev_rd = x.rd;
    exp_id++;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf_val[i] = (i == 0) ? 32'd0 : 32'h1000 + 32'(i) * 32'd17;
      rf_busy[i] = 1'b0;
      rf_tag[i] = '0;
    end
    repeat (2) step();
    rst = 1'b0;
    step();
    chk("rst_if_ready", if_ready, 1'b1);
    chk("rst_rob_valid", out_rob_valid, 1'b0);
    chk("rst_redir_valid", redir_valid, 1'b0);
    chk("rst_redir_pc", redir_pc, 32'h0);
    chk("rst_rename", rename_valid, 1'b0);
    chk("rst_imm", out_imm, 32'h0);

    push(32'h0, enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13));
    push(32'h4, enc_r(7'd0, 5'd1, 5'd1, 3'd0, 5'd2));
    chk("addi_rs_valid", out_rs_valid, 1'b1);
    chk("addi_lsb_valid", out_lsb_valid, 1'b0);
    chk("addi_rob_id", out_rob_id, 0);
    chk("addi_v2", out_v2, 32'd5);
    chk("addi_has_q1", out_has_q1, 1'b0);
    chk("addi_rename", rename_valid, 1'b1);
    step();
    chk("add_has_q1", out_has_q1, 1'b1);
    chk("add_q1", out_q1, 0);
    chk("add_has_q2", out_has_q2, 1'b1);
    chk("add_q2", out_q2, 0);
    chk("add_rob_id", out_rob_id, 1);
    chk("add_rd", out_rd, 2);
    step();
    chk("idle_rob_valid", out_rob_valid, 1'b0);

    rob_full = 1'b1;
    push(32'h100, enc_b(13'h1ff8, 5'd1, 5'd2, 3'd0));
    push(32'h104, enc_i(12'd1, 5'd0, 3'd0, 5'd5, 7'h13));
    push(32'h108, enc_i(12'd2, 5'd0, 3'd0, 5'd6, 7'h13));
    chk("robfull_stall", out_rob_valid, 1'b0);
    rob_full = 1'b0;
    step();
    chk("beq_rob_valid", out_rob_valid, 1'b1);
    chk("beq_rs_valid", out_rs_valid, 1'b1);
    chk("beq_pred", out_pred_taken, 1'b1);
    chk("beq_redir_valid", redir_valid, 1'b1);
    chk("beq_redir_pc", redir_pc, 32'hf8);
    chk("beq_rob_id", out_rob_id, 2);
    chk("beq_imm", out_imm, 32'hffff_fff8);
    chk("beq_v1", out_v1, rf_val[2]);
    chk("beq_rename", rename_valid, 1'b0);
    step();
    chk("redir_pulse", redir_valid, 1'b0);
    chk("young_drop_a", out_rob_valid, 1'b0);
    step();
    chk("young_drop_b", out_rob_valid, 1'b0);
    push(32'h200, enc_b(13'd16, 5'd0, 5'd0, 3'd1));
    step();
    chk("bne_rob_valid", out_rob_valid, 1'b1);
    chk("bne_pred", out_pred_taken, 1'b0);
    chk("bne_redir", redir_valid, 1'b0);
    chk("bne_rob_id", out_rob_id, 3);
    chk("bne_imm", out_imm, 32'd16);

    rf_busy[5] = 1'b1;
    rf_tag[5] = 4'd9;
    push(32'h40, enc_i(12'd0, 5'd5, 3'd0, 5'd1, 7'h67));
    push(32'h44, enc_i(12'd7, 5'd0, 3'd0, 5'd7, 7'h13));
    chk("jalr_rob_valid", out_rob_valid, 1'b1);
    chk("jalr_rs_valid", out_rs_valid, 1'b0);
    chk("jalr_imm", out_imm, 32'h44);
    chk("jalr_rob_id", out_rob_id, 4);
    chk("jalr_has_q1", out_has_q1, 1'b1);
    chk("jalr_q1", out_q1, 9);
    chk("jalr_rename", rename_valid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_jalr_nodisp", out_rob_valid, 1'b0);
    end
    flush = 1'b1;
    flush_tail = 4'd3;
    step();
    flush = 1'b0;
    chk("flush_strobe", out_rob_valid, 1'b0);
    chk("flush_redir", redir_valid, 1'b0);
    step();
    chk("flush_queue_empty", out_rob_valid, 1'b0);
    rf_busy[5] = 1'b0;
    push(32'h80, enc_i(12'd1, 5'd0, 3'd0, 5'd7, 7'h13));
    step();
    chk("flush_resume_valid", out_rob_valid, 1'b1);
    chk("flush_resume_id", out_rob_id, 3);
    chk("flush_resume_pc", out_pc, 32'h80);

    lsb_full = 1'b1;
    for (int i = 0; i < 4; i++) push(32'h500 + 32'(4 * i), enc_i(12'(4 * i), 5'd0, 3'd2, 5'(10 + i), 7'h03));
    chk("full_if_ready", if_ready, 1'b0);
    chk("lsbfull_stall", out_rob_valid, 1'b0);
    lsb_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ld_lsb_valid", out_lsb_valid, 1'b1);
      chk("ld_pc", out_pc, 32'h500 + 32'(4 * i));
      chk("ld_rob_id", out_rob_id, 32'(4 + i));
      chk("ld_imm", out_imm, 32'(4 * i));
    end
    step();
    chk("ld_drained", out_rob_valid, 1'b0);

    push(32'h300, enc_u(20'h12345, 5'd3, 7'h37));
    step();
    chk("lui_imm", out_imm, 32'h1234_5000);
    chk("lui_rob_valid", out_rob_valid, 1'b1);
    chk("lui_rs_valid", out_rs_valid, 1'b0);
    chk("lui_lsb_valid", out_lsb_valid, 1'b0);
    chk("lui_rename", rename_valid, 1'b1);
    chk("lui_rob_id", out_rob_id, 8);
    push(32'h400, 32'hff9f_f06f);
    step();
    chk("exit_flag", out_exit, 1'b1);
    chk("exit_redir_valid", redir_valid, 1'b1);
    chk("exit_redir_pc", redir_pc, 32'h3f8);
    chk("exit_rename", rename_valid, 1'b0);
    chk("exit_rob_id", out_rob_id, 9);
    step();

    rob_full = 1'b1;
    push(32'h600, enc_i(12'd1, 5'd0, 3'd0, 5'd8, 7'h13));
    push(32'h604, enc_i(12'd2, 5'd0, 3'd0, 5'd9, 7'h13));
    rob_full = 1'b0;
    step();
    chk("pre_rst_valid", out_rob_valid, 1'b1);
    chk("pre_rst_pc", out_pc, 32'h600);
    rdy = 1'b0;
    step();
    chk("freeze_valid", out_rob_valid, 1'b1);
    chk("freeze_pc", out_pc, 32'h600);
    rdy = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("arst_rob_valid", out_rob_valid, 1'b0);
    chk("arst_rename", rename_valid, 1'b0);
    chk("arst_pc", out_pc, 32'h0);
    chk("arst_redir", redir_valid, 1'b0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_empty", out_rob_valid, 1'b0);
    chk("post_rst_ready", if_ready, 1'b1);

    for (int i = 1; i < 32; i++) begin
      rf_val[i] = $urandom;
      rf_busy[i] = 1'($urandom_range(0, 1));
      rf_tag[i] = 4'($urandom_range(0, 15));
    end
    sent = 0;
    idle = 0;
    prev_cyc = -10;
    prev_ren = 1'b0;
    prev_rd = '0;
    exp_id = 0;
    pc_ctr = 32'h1000;
    for (int c = 0; c < 1000; c++) begin
      if (sent == NRND && exp_q.size() == 0) break;
      if_valid = 1'b0;
      if (sent < NRND && if_ready && $urandom_range(0, 3) != 0) begin
        r.kind = int'($urandom_range(0, 6));
        r.rd = 5'($urandom_range(0, 7));
        r.rs1 = 5'($urandom_range(0, 7));
        r.rs2 = 5'($urandom_range(0, 7));
        r.f3 = 3'($urandom_range(0, 7));
        r.f7b5 = 1'($urandom_range(0, 1));
        r.pc = pc_ctr;
        pc_ctr = pc_ctr + 32'd4;
        simm = int'($urandom_range(0, 4095)) - 2048;
        r.imm = 32'(simm);
        u = $urandom;
        case (r.kind)
          0: inst = enc_r(r.f7b5 ? 7'h20 : 7'h00, r.rs2, r.rs1, r.f3, r.rd);
          1: begin
            if (r.f3[1:0] == 2'b01) r.f3 = 3'd0;
            inst = enc_i(12'(simm), r.rs1, r.f3, r.rd, 7'h13);
          end
          2: begin
            r.f3 = r.f3[2] ? 3'd5 : 3'd1;
            shamt = int'($urandom_range(0, 31));
            r.imm = 32'(shamt);
            inst = enc_i({r.f7b5 ? 7'h20 : 7'h00, 5'(shamt)}, r.rs1, r.f3, r.rd, 7'h13);
          end
          3: begin
            r.f3 = 3'd2;
            inst = enc_i(12'(simm), r.rs1, r.f3, r.rd, 7'h03);
          end
          4: begin
            r.f3 = 3'd2;
            inst = enc_s(12'(simm), r.rs2, r.rs1, r.f3);
          end
          default: begin
            r.imm = {u[19:0], 12'h000};
            inst = enc_u(u[19:0], r.rd, r.kind == 5 ? 7'h37 : 7'h17);
          end
        endcase
        exp_q.push_back(r);
        sent++;
        if_valid = 1'b1;
        if_pc = r.pc;
        if_inst = inst;
      end
      step();
      if_valid = 1'b0;
      if (out_rob_valid) begin
        if (exp_q.size() == 0) chk("rnd_spurious", out_rob_valid, 1'b0);
        else begin
          e = exp_q.pop_front();
          check_rec(e);
          idle = 0;
        end
      end else if (exp_q.size() > 0) begin
        idle++;
        if (idle > 3) begin
          chk("rnd_timeout", out_rob_valid, 1'b1);
          break;
        end
      end
    end
    chk("rnd_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
